obi_data_responder: RTL and testbench
=====================================

OBI_DATA_RESPONDER -- requirements
Module: obi_data_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 2, maximum outstanding (granted, not yet responded) transactions, range 1..8.
REQ-002 SHALL have parameter LATENCY, default 1, minimum cycles from grant to rvalid, range 1..7.
REQ-003 SHALL have parameter MEM_WORDS, default 256, backing memory size in 32-bit words, power of two.
REQ-004 SHALL have ports: clk_i in 1 clock; rst_ni in 1 reset, synchronous, active-low.
REQ-005 SHALL have ports: data_req_i in 1 request; data_gnt_o out 1 grant; data_rvalid_o out 1 response valid.
REQ-006 SHALL have ports: data_we_i in 1 write enable; data_be_i in 4 byte enables; data_addr_i in 32 byte address.
REQ-007 SHALL have ports: data_wdata_i in 32 write data; data_rdata_o out 32 read data; outstanding_o out 4 current outstanding count.

Function
REQ-008 SHALL drive data_gnt_o = data_req_i & (outstanding < DEPTH) & !stall, combinationally, with stall as defined in Configuration; no gnt without req.
REQ-009 SHALL, at a full FIFO, withhold gnt even if rvalid pops in the same cycle (no full bypass).
REQ-010 SHALL treat a cycle with req & gnt as an accepted transaction and push it into an in-order response FIFO of DEPTH entries.
REQ-011 SHALL index memory by word = data_addr_i[2 +: log2(MEM_WORDS)]; upper address bits and addr[1:0] ignored (aliasing wrap-around).
REQ-012 SHALL, on an accepted write, update only the byte lanes with data_be_i set, at the acceptance clock edge; be=0000 leaves memory unchanged.
REQ-013 SHALL, on an accepted read, capture the full memory word at acceptance (reflecting all earlier accepted writes) into the FIFO entry.
REQ-014 SHALL store rdata = 0 for write entries.
REQ-015 SHALL keep a saturating age counter per entry, 0 at push, +1 each cycle.
REQ-016 SHALL assert data_rvalid_o for exactly one cycle per entry, in grant order, when the head entry age >= LATENCY, then pop it.
REQ-017 SHALL keep data_rdata_o valid only while data_rvalid_o=1, and drive it to 0 otherwise.
REQ-018 SHALL compute the next outstanding count as +1 for a push only, -1 for a pop only, unchanged for push and pop together; outstanding_o SHALL never exceed DEPTH.
REQ-019 SHALL sustain back-to-back throughput of one grant and one rvalid per cycle when DEPTH > LATENCY.

Reset
REQ-020 SHALL, on rst_ni=0 at a clock edge, empty the FIFO, clear ages, and drive outstanding_o=0, data_rvalid_o=0, data_rdata_o=0; data_gnt_o SHALL be 0 while rst_ni=0.
REQ-021 SHALL discard in-flight transactions on reset mid-operation and emit no rvalid for them.
REQ-022 SHALL NOT reset memory contents; all words SHALL be initialised to 0 at time zero only.

Configuration
REQ-023 SHALL, with OBI_RESP_STALL_EN defined, derive stall from bit 0 of a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advancing every cycle, so gnt is withheld pseudo-randomly.
REQ-024 SHALL, without OBI_RESP_STALL_EN, hold stall constant 0 and omit the LFSR logic.

Structure
REQ-025 SHALL place the FIFO entry struct (we, rdata, age) typedef, the LFSR seed and taps constants, and the parameter range limits in package obi_resp_pkg.
REQ-026 SHALL implement the response FIFO as sub-module obi_resp_fifo (push, pop, full, empty, count); memory and grant logic SHALL stay in the top module.

Verification
REQ-027 SHALL cover: write addr 0x10, be=1111, wdata 0xDEADBEEF, then read 0x10 (LATENCY=1) -> gnt same cycle, rvalid 1 cycle after each grant, rdata 0xDEADBEEF on the second rvalid.
REQ-028 SHALL cover: partial write addr 0x10, be=0101, wdata 0x11223344 over 0xDEADBEEF, then read -> rdata 0xDE22BE44.
REQ-029 SHALL cover: DEPTH=2, LATENCY=4, continuous req -> two grants, gnt low while outstanding_o=2, first rvalid 4 cycles after first grant, and no grant in the cycle of the first rvalid.
REQ-030 SHALL cover: write addr 0x400 with MEM_WORDS=256, then read addr 0x0 -> same word returned (aliasing).
REQ-031 SHALL cover: rst_ni low for one cycle with outstanding_o=2 -> no further rvalid, outstanding_o=0, memory data retained on a later read.
REQ-032 SHALL cover: OBI_RESP_STALL_EN defined, 1000 cycles of random req -> gnt never without req, outstanding_o never above DEPTH, rvalid count equals grant count after drain.

Source files
------------

// File: rtl/obi_data_responder_pkg.sv
// obi_resp_pkg: shared types and constants for the OBI data responder.
// Holds the response FIFO entry, LFSR constants and parameter limits.
package obi_resp_pkg;

  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 8;
  localparam int LAT_MIN   = 1;
  localparam int LAT_MAX   = 7;

  localparam int AGE_W = 3;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // taps 16,14,13,11 as a mask over bits [15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic             we;
    logic [31:0]      rdata;
    logic [AGE_W-1:0] age;
  } entry_t;

  function automatic logic [AGE_W-1:0] age_inc(
    input logic [AGE_W-1:0] a
  );
    return (&a) ? a : a + AGE_W'(1);
  endfunction

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/obi_data_responder_if.sv
// obi_data_responder_if: OBI data-side request/response bundle.
// master issues requests, slave answers with gnt/rvalid/rdata.
interface obi_data_responder_if;

  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;

  modport master (
    output data_req_i,
    output data_we_i,
    output data_be_i,
    output data_addr_i,
    output data_wdata_i,
    input  data_gnt_o,
    input  data_rvalid_o,
    input  data_rdata_o
  );

  modport slave (
    input  data_req_i,
    input  data_we_i,
    input  data_be_i,
    input  data_addr_i,
    input  data_wdata_i,
    output data_gnt_o,
    output data_rvalid_o,
    output data_rdata_o
  );

endinterface

// File: rtl/obi_data_responder_fifo.sv
// obi_resp_fifo: in-order response FIFO with a saturating age per entry.
// The grant cycle itself counts as one cycle of age.
module obi_resp_fifo
  import obi_resp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  entry_t     entry_i,
  input  logic       pop_i,
  output entry_t     head_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [3:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  entry_t        ent_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [3:0]    cnt_q, cnt_d;

  // pointer wrap and occupancy bookkeeping
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (pop_i)
      rd_d = (rd_q == LAST) ? '0 : rd_q + PW'(1);
    if (push_i)
      wr_d = (wr_q == LAST) ? '0 : wr_q + PW'(1);
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 4'd1;
      2'b01:   cnt_d = cnt_q - 4'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // store entries and age every slot each cycle
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        ent_q[i].age <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++)
        ent_q[i].age <= age_inc(ent_q[i].age);
      if (push_i)
        ent_q[wr_q] <= '{
          we:    entry_i.we,
          rdata: entry_i.rdata,
          age:   age_inc(entry_i.age)
        };
    end
  end

  assign head_o  = ent_q[rd_q];
  assign full_o  = (cnt_q == 4'(DEPTH));
  assign empty_o = (cnt_q == 4'd0);
  assign count_o = cnt_q;

endmodule

// File: rtl/obi_data_responder.sv
// obi_data_responder: OBI data slave with backing memory and fixed latency.
// Define OBI_RESP_STALL_EN to withhold gnt pseudo-randomly via an LFSR.
module obi_data_responder
  import obi_resp_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int LATENCY   = 1,
  parameter int MEM_WORDS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  obi_data_responder_if.slave  bus,
  output logic [3:0]           outstanding_o
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0] mem_q [MEM_WORDS] = '{default: '0};

  logic [AW-1:0] word;
  logic          stall;
  logic          gnt;
  logic          pop;
  logic          full;
  logic          empty;
  logic [3:0]    count;
  entry_t        push_ent;
  entry_t        head;
  logic          unused_addr;

  assign word = bus.data_addr_i[2 +: AW];
  assign unused_addr = ^{bus.data_addr_i[31:2+AW],
                         bus.data_addr_i[1:0]};

`ifdef OBI_RESP_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = lfsr_next(lfsr_q);
  assign stall  = lfsr_q[0];

  // free-running stall generator
  always_ff @(posedge clk_i) begin
    if (!rst_ni) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= lfsr_d;
  end
`else
  assign stall = 1'b0;
`endif

  // a full FIFO blocks grant even if the head pops this cycle
  assign gnt = rst_ni & bus.data_req_i & ~full & ~stall;
  assign pop = rst_ni & ~empty
             & (head.age >= AGE_W'(LATENCY));

  assign bus.data_gnt_o    = gnt;
  assign bus.data_rvalid_o = pop;
  assign bus.data_rdata_o  = pop ? head.rdata : '0;
  assign outstanding_o     = count;

  // read data is sampled at acceptance, writes answer with zero
  assign push_ent = '{
    we:    bus.data_we_i,
    rdata: bus.data_we_i ? '0 : mem_q[word],
    age:   '0
  };

  // byte-lane write on accepted stores; memory survives reset
  always_ff @(posedge clk_i) begin
    if (gnt && bus.data_we_i) begin
      for (int b = 0; b < 4; b++)
        if (bus.data_be_i[b])
          mem_q[word][8*b +: 8] <= bus.data_wdata_i[8*b +: 8];
    end
  end

  obi_resp_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (gnt),
    .entry_i (push_ent),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

endmodule

// File: tb/tb_obi_data_responder.sv
// tb_obi_data_responder: directed and random checks of the OBI responder.
// dut_a runs against a queue/array model, dut_b against cycle tables.
module tb_obi_data_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_na, rst_nb;
  logic [3:0] out_a, out_b;

  obi_data_responder_if bus_a ();
  obi_data_responder_if bus_b ();

  obi_data_responder #(
    .DEPTH(4), .LATENCY(1), .MEM_WORDS(256)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_na),
    .bus(bus_a), .outstanding_o(out_a)
  );

  obi_data_responder #(
    .DEPTH(2), .LATENCY(4), .MEM_WORDS(256)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_nb),
    .bus(bus_b), .outstanding_o(out_b)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          we;
    logic [31:0] rdata;
    int          gcyc;
  } ment_t;

  ment_t       mq[$];
  logic [31:0] mmem [256];
  int          cyc = 0;
  logic [15:0] mlfsr = 16'hACE1;
  logic [31:0] rd_last = 32'h0;
  int          gnt_cnt = 0;
  int          rv_cnt = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_a(input bit req, input bit we,
                         input logic [3:0] be,
                         input logic [31:0] addr,
                         input logic [31:0] wd);
    bus_a.data_req_i   = req;
    bus_a.data_we_i    = we;
    bus_a.data_be_i    = be;
    bus_a.data_addr_i  = addr;
    bus_a.data_wdata_i = wd;
  endtask

  // one clock of dut_a: compare against the model, then advance it
  task automatic step_a(output bit g);
    bit          stall;
    bit          ev;
    logic [31:0] ed;
    logic [7:0]  w;
    @(negedge clk);
    stall = 1'b0;
`ifdef OBI_RESP_STALL_EN
    stall = mlfsr[0];
`endif
    g  = rst_na && bus_a.data_req_i && (mq.size() < 4) && !stall;
    ev = rst_na && (mq.size() > 0) && (cyc - mq[0].gcyc >= 1);
    ed = ev ? mq[0].rdata : 32'h0;
    check("a_gnt", 32'(bus_a.data_gnt_o), 32'(g));
    check("a_rvalid", 32'(bus_a.data_rvalid_o), 32'(ev));
    check("a_rdata", bus_a.data_rdata_o, ed);
    check("a_outstanding", 32'(out_a), 32'(mq.size()));
    check("a_out_le_depth", 32'(out_a <= 4'd4), 32'd1);
    if (bus_a.data_rvalid_o) rd_last = bus_a.data_rdata_o;
    gnt_cnt += int'(bus_a.data_gnt_o);
    rv_cnt  += int'(bus_a.data_rvalid_o);
    if (!rst_na) begin
      mq.delete();
      mlfsr = 16'hACE1;
    end else begin
      mlfsr = {mlfsr[14:0],
               mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
      if (ev) void'(mq.pop_front());
      if (g) begin
        w = bus_a.data_addr_i[9:2];
        mq.push_back('{we: bus_a.data_we_i,
                       rdata: bus_a.data_we_i ? 32'h0 : mmem[w],
                       gcyc: cyc});
        if (bus_a.data_we_i)
          for (int b = 0; b < 4; b++)
            if (bus_a.data_be_i[b])
              mmem[w][8*b +: 8] = bus_a.data_wdata_i[8*b +: 8];
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a(input int n);
    bit g;
    for (int i = 0; i < n; i++) step_a(g);
  endtask

  // hold a request until the model says it is granted
  task automatic xact_a(input bit we, input logic [3:0] be,
                        input logic [31:0] addr,
                        input logic [31:0] wd);
    bit g;
    g = 1'b0;
    drive_a(1'b1, we, be, addr, wd);
    for (int i = 0; i < 64 && !g; i++) step_a(g);
    check("a_granted", 32'(g), 32'd1);
    drive_a(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // one clock of dut_b against explicit expectations
  task automatic cyc_b(input bit req, input bit we,
                       input logic [31:0] addr,
                       input bit eg, input bit ev,
                       input logic [31:0] ed, input int eo,
                       input string tag);
    bus_b.data_req_i   = req;
    bus_b.data_we_i    = we;
    bus_b.data_be_i    = 4'hF;
    bus_b.data_addr_i  = addr;
    bus_b.data_wdata_i = 32'hCAFEF00D;
    @(negedge clk);
    check({tag, "_gnt"}, 32'(bus_b.data_gnt_o), 32'(eg));
    check({tag, "_rvalid"}, 32'(bus_b.data_rvalid_o), 32'(ev));
    check({tag, "_rdata"}, bus_b.data_rdata_o, ed);
    check({tag, "_out"}, 32'(out_b), 32'(eo));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] eg_b;
    logic [6:0] ev_b;
    int         eo_b [7];
    bit         g;

    for (int i = 0; i < 256; i++) mmem[i] = 32'h0;
    rst_na = 1'b0;
    rst_nb = 1'b0;
    drive_a(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    bus_b.data_req_i   = 1'b0;
    bus_b.data_we_i    = 1'b0;
    bus_b.data_be_i    = 4'h0;
    bus_b.data_addr_i  = 32'h0;
    bus_b.data_wdata_i = 32'h0;
    @(posedge clk);
    #1;

`ifndef OBI_RESP_STALL_EN
    cyc_b(1'b1, 1'b0, 32'h40, 0, 0, 32'h0, 0, "b_rst");
    cyc_b(1'b1, 1'b0, 32'h40, 0, 0, 32'h0, 0, "b_rst");
    rst_nb = 1'b1;
    eg_b = 7'b1100011;
    ev_b = 7'b0110000;
    eo_b = '{0, 1, 2, 2, 2, 1, 1};
    for (int c = 0; c < 7; c++)
      cyc_b(1'b1, c == 0, 32'h40, eg_b[c], ev_b[c],
            (c == 5) ? 32'hCAFEF00D : 32'h0, eo_b[c], "b_run");
    rst_nb = 1'b0;
    cyc_b(1'b0, 1'b0, 32'h0, 0, 0, 32'h0, 2, "b_midrst");
    rst_nb = 1'b1;
    for (int c = 0; c < 6; c++)
      cyc_b(1'b0, 1'b0, 32'h0, 0, 0, 32'h0, 0, "b_drop");
    cyc_b(1'b1, 1'b0, 32'h40, 1, 0, 32'h0, 0, "b_reread");
    for (int c = 0; c < 3; c++)
      cyc_b(1'b0, 1'b0, 32'h0, 0, 0, 32'h0, 1, "b_wait");
    cyc_b(1'b0, 1'b0, 32'h0, 0, 1, 32'hCAFEF00D, 1, "b_retained");
    cyc_b(1'b0, 1'b0, 32'h0, 0, 0, 32'h0, 0, "b_done");
`endif

    drive_a(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    step_a(g);
    step_a(g);
    rst_na = 1'b1;
    drive_a(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    idle_a(1);

    xact_a(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    xact_a(1'b0, 4'h0, 32'h10, 32'h0);
    idle_a(3);
    check("rd_full_word", rd_last, 32'hDEADBEEF);

    rd_last = 32'h0;
    xact_a(1'b1, 4'b0101, 32'h10, 32'h11223344);
    xact_a(1'b0, 4'h0, 32'h10, 32'h0);
    idle_a(3);
    check("rd_partial", rd_last, 32'hDE22BE44);

    rd_last = 32'h0;
    xact_a(1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF);
    xact_a(1'b0, 4'h0, 32'h10, 32'h0);
    idle_a(3);
    check("rd_be_none", rd_last, 32'hDE22BE44);

    rd_last = 32'h0;
    xact_a(1'b1, 4'hF, 32'h400, 32'h5A5A1234);
    xact_a(1'b0, 4'h0, 32'h0, 32'h0);
    idle_a(3);
    check("rd_alias", rd_last, 32'h5A5A1234);

    gnt_cnt = 0;
    rv_cnt  = 0;
    for (int i = 0; i < 1000; i++) begin
      drive_a($urandom_range(0, 99) < 60,
              1'($urandom_range(0, 1)),
              4'($urandom),
              $urandom & 32'hFFFF_F03F,
              $urandom);
      step_a(g);
    end
    drive_a(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    idle_a(10);
    check("drain_balance", 32'(rv_cnt), 32'(gnt_cnt));
    check("drain_empty", 32'(out_a), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
